// File: rtl/rsa_seq_pkg.sv
// Shared types and encodings for the RSA exponentiation sequencer.
package rsa_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] KEY_N = 2'd0;
    localparam logic [1:0] KEY_E = 2'd1;
    localparam logic [1:0] KEY_D = 2'd2;

    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

endpackage

// File: rtl/rsa_key_regs.sv
// RSA key storage (n, e, d) with write acceptance and a one-cycle reject pulse.
module rsa_key_regs
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_we_i,
    input  logic [1:0]       key_sel_i,
    input  logic [WIDTH-1:0] key_wdata_i,
    input  logic             idle_i,
    input  logic             req_take_i,
    output logic [WIDTH-1:0] key_n_o,
    output logic [WIDTH-1:0] key_e_o,
    output logic [WIDTH-1:0] key_d_o,
    output logic             key_err_o
);

    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             err_q, err_d;
    logic             wr_ok;

    // A write only lands while idle and not racing an accepted request.
    always_comb begin
        wr_ok = key_we_i && idle_i && !req_take_i && (key_sel_i != 2'd3);
        n_d   = n_q;
        e_d   = e_q;
        d_d   = d_q;
        err_d = key_we_i && !wr_ok;
        if (wr_ok) begin
            case (key_sel_i)
                KEY_N:   n_d = key_wdata_i;
                KEY_E:   e_d = key_wdata_i;
                KEY_D:   d_d = key_wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            e_q   <= '0;
            d_q   <= '0;
            err_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            e_q   <= e_d;
            d_q   <= d_d;
            err_q <= err_d;
        end
    end

    assign key_n_o   = n_q;
    assign key_e_o   = e_q;
    assign key_d_o   = d_q;
    assign key_err_o = err_q;

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Drives the mod_exp engine for one RSA encrypt/decrypt job at a time, with range
// checking, an engine timeout and a held valid/ready response.
module rsa_exp_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH   = 1024,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_we,
    input  logic [1:0]         key_sel,
    input  logic [WIDTH-1:0]   key_wdata,
    output logic               key_err,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [WIDTH-1:0]   req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               rsp_op,
    output logic               busy,
    output logic               exp_rst_n,
    output logic [2*WIDTH-1:0] exp_base,
    output logic [2*WIDTH-1:0] exp_modulo,
    output logic [2*WIDTH-1:0] exp_exponent,
    input  logic               exp_finish,
    input  logic [2*WIDTH-1:0] exp_result
);

    localparam int CNT_W = $clog2(TIMEOUT+1);

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] expo_q, expo_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] key_n, key_e, key_d;
    logic             req_take;
    logic             unused_result_hi;

    assign req_take         = (state_q == ST_IDLE) && req_valid;
    assign unused_result_hi = ^exp_result[2*WIDTH-1:WIDTH];

    rsa_key_regs #(.WIDTH(WIDTH)) u_keys (
        .clk         (clk),
        .rst         (rst),
        .key_we_i    (key_we),
        .key_sel_i   (key_sel),
        .key_wdata_i (key_wdata),
        .idle_i      (state_q == ST_IDLE),
        .req_take_i  (req_take),
        .key_n_o     (key_n),
        .key_e_o     (key_e),
        .key_d_o     (key_d),
        .key_err_o   (key_err)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        base_d  = base_q;
        mod_d   = mod_q;
        expo_d  = expo_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    base_d = req_data;
                    mod_d  = key_n;
                    expo_d = (req_op == OP_DEC) ? key_d : key_e;
                    // Out-of-range messages are answered without touching the engine.
                    if ((key_n == '0) || (req_data >= key_n)) begin
                        rerr_d  = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (exp_finish) begin
                    rdata_d = exp_result[WIDTH-1:0];
                    rerr_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            base_q  <= '0;
            mod_q   <= '0;
            expo_q  <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            mod_q   <= mod_d;
            expo_q  <= expo_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign busy         = (state_q != ST_IDLE);
    assign exp_rst_n    = (state_q == ST_RUN);
    assign rsp_data     = rdata_q;
    assign rsp_err      = rerr_q;
    assign rsp_op       = op_q;
    assign exp_base     = {{WIDTH{1'b0}}, base_q};
    assign exp_modulo   = {{WIDTH{1'b0}}, mod_q};
    assign exp_exponent = {{WIDTH{1'b0}}, expo_q};

endmodule

// File: tb/tb_rsa_exp_sequencer.sv
// Randomised self-checking bench for rsa_exp_sequencer with an arithmetic engine stub.
module tb_rsa_exp_sequencer;
    import rsa_seq_pkg::*;

    localparam int W  = 16;
    localparam int TO = 2*W+8;

    logic           clk;
    logic           rst;
    logic           key_we;
    logic [1:0]     key_sel;
    logic [W-1:0]   key_wdata;
    logic           key_err;
    logic           req_valid;
    logic           req_ready;
    logic           req_op;
    logic [W-1:0]   req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           rsp_op;
    logic           busy;
    logic           exp_rst_n;
    logic [2*W-1:0] exp_base;
    logic [2*W-1:0] exp_modulo;
    logic [2*W-1:0] exp_exponent;
    logic           exp_finish;
    logic [2*W-1:0] exp_result;

    int checks   = 0;
    int failures = 0;
    int unsigned mN = 0, mE = 0, mD = 0;
    int runCnt;
    logic stubHang = 1'b0;

    rsa_exp_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .key_we(key_we), .key_sel(key_sel), .key_wdata(key_wdata), .key_err(key_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_op(rsp_op), .busy(busy),
        .exp_rst_n(exp_rst_n), .exp_base(exp_base), .exp_modulo(exp_modulo),
        .exp_exponent(exp_exponent), .exp_finish(exp_finish), .exp_result(exp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned modExp(input int unsigned b, input int unsigned e,
                                           input int unsigned m);
        longint unsigned r, x;
        int unsigned k;
        if (m <= 1) return 0;
        r = 1;
        x = longint'(b) % m;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return int'(r);
    endfunction

    function automatic int bitLen(input int unsigned v);
        int n = 0;
        for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Engine stub: result is ready once it has run bit-length+1 cycles out of reset.
    always @(posedge clk) begin
        if (!exp_rst_n) runCnt <= 0;
        else            runCnt <= runCnt + 1;
    end

    always_comb begin
        exp_result = '0;
        exp_result[W-1:0] = W'(modExp(int'(exp_base), int'(exp_exponent), int'(exp_modulo)));
    end

    assign exp_finish = exp_rst_n && !stubHang && (runCnt >= bitLen(int'(exp_exponent)) + 1);

    always @(negedge clk) begin
        if (exp_finish && exp_result[2*W-1:W] != '0) $error("[TB] engine result upper half nonzero");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic writeKey(input logic [1:0] sel, input int unsigned val, input logic expErr,
                            input string tag);
        key_we    = 1'b1;
        key_sel   = sel;
        key_wdata = W'(val);
        stepCycle();
        key_we = 1'b0;
        checkOutput({tag, "_keyerr"}, 32'(key_err), 32'(expErr));
        if (!expErr) begin
            case (sel)
                KEY_N:   mN = val;
                KEY_E:   mE = val;
                KEY_D:   mD = val;
                default: ;
            endcase
        end
    endtask

    // kwMode: 0 none, 1 key write alongside the request, 2 key write while running.
    task automatic applyStimulus(input logic op, input int unsigned data, input int holdCycles,
                                 input int kwMode, input string tag);
        int unsigned key, expData;
        logic expErr, sawRst;
        int expLat, lat;
        logic [W-1:0] heldData;
        logic heldErr;

        key = (op == OP_DEC) ? mD : mE;
        if (mN == 0 || data >= mN) begin
            expErr = 1'b1; expData = 0; expLat = 1;
        end else if (stubHang) begin
            expErr = 1'b1; expData = 0; expLat = TO + 2;
        end else begin
            expErr = 1'b0; expData = modExp(data, key, mN); expLat = bitLen(key) + 4;
        end

        checkOutput({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = W'(data);
        if (kwMode == 1) begin
            key_we = 1'b1; key_sel = KEY_E; key_wdata = 16'h0BAD;
        end
        stepCycle();
        req_valid = 1'b0;
        key_we    = 1'b0;
        if (kwMode == 1) checkOutput({tag, "_raceerr"}, 32'(key_err), 32'd1);

        lat = 1;
        sawRst = exp_rst_n;
        while (!rsp_valid && lat < 200) begin
            if (kwMode == 2 && lat == 2) begin
                key_we = 1'b1; key_sel = KEY_E; key_wdata = 16'h1234;
            end
            stepCycle();
            key_we = 1'b0;
            lat++;
            if (exp_rst_n) sawRst = 1'b1;
            if (kwMode == 2 && lat == 3) checkOutput({tag, "_runkeyerr"}, 32'(key_err), 32'd1);
            if (kwMode == 2 && lat == 4) checkOutput({tag, "_pulse"}, 32'(key_err), 32'd0);
        end

        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_data"}, 32'(rsp_data), expData);
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, "_op"}, 32'(rsp_op), 32'(op));
        if (expLat == 1) checkOutput({tag, "_norun"}, 32'(sawRst), 32'd0);

        heldData = rsp_data;
        heldErr  = rsp_err;
        for (int i = 0; i < holdCycles; i++) begin
            stepCycle();
            checkOutput({tag, "_holdv"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, "_holdd"}, 32'(rsp_data), 32'(heldData));
            checkOutput({tag, "_holde"}, 32'(rsp_err), 32'(heldErr));
            checkOutput({tag, "_holdrdy"}, 32'(req_ready), 32'd0);
            checkOutput({tag, "_holdbusy"}, 32'(busy), 32'd1);
        end

        // A request presented on the handshake cycle must not be taken.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        stepCycle();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput({tag, "_done_v"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int unsigned n, dataMax;
        rst = 1'b1; key_we = 1'b0; key_sel = '0; key_wdata = '0;
        req_valid = 1'b0; req_op = 1'b0; req_data = '0; rsp_ready = 1'b0;
        stepCycle();
        stepCycle();
        rst = 1'b0;

        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_op", 32'(rsp_op), 32'd0);
        checkOutput("rst_keyerr", 32'(key_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_exprstn", 32'(exp_rst_n), 32'd0);
        checkOutput("rst_base", exp_base, 32'd0);

        writeKey(KEY_N, 3233, 1'b0, "wn");
        writeKey(KEY_E, 17, 1'b0, "we");
        writeKey(KEY_D, 2753, 1'b0, "wd");
        writeKey(2'd3, 99, 1'b1, "wsel3");

        applyStimulus(OP_ENC, 65, 0, 0, "enc65");
        checkOutput("enc65_const", 32'(modExp(65, 17, 3233)), 32'd2790);
        applyStimulus(OP_DEC, 2790, 5, 0, "dec");
        applyStimulus(OP_ENC, 3233, 0, 0, "range");
        applyStimulus(OP_ENC, 100, 0, 1, "race");
        applyStimulus(OP_ENC, 123, 0, 2, "runkw");
        applyStimulus(OP_ENC, 123, 0, 0, "keykept");

        stubHang = 1'b1;
        applyStimulus(OP_ENC, 65, 0, 0, "hang");
        stubHang = 1'b0;

        writeKey(KEY_E, 0, 1'b0, "we0");
        applyStimulus(OP_ENC, 65, 0, 0, "ezero");

        for (int it = 0; it < 16; it++) begin
            n = $urandom_range(2, 65535);
            writeKey(KEY_N, n, 1'b0, "rn");
            writeKey(KEY_E, $urandom_range(0, 65535), 1'b0, "re");
            writeKey(KEY_D, $urandom_range(0, 65535), 1'b0, "rd");
            dataMax = n + n / 8;
            if (dataMax > 65535) dataMax = 65535;
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, dataMax),
                          $urandom_range(0, 2), 0, "rand");
        end

        writeKey(KEY_N, 3233, 1'b0, "wn2");
        writeKey(KEY_E, 17, 1'b0, "we2");
        req_valid = 1'b1; req_op = OP_ENC; req_data = 16'd65;
        stepCycle();
        req_valid = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("mid_run", 32'(exp_rst_n), 32'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        mN = 0; mE = 0; mD = 0;
        checkOutput("rr_ready", 32'(req_ready), 32'd1);
        checkOutput("rr_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rr_exprstn", 32'(exp_rst_n), 32'd0);
        checkOutput("rr_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) stepCycle();
        checkOutput("rr_noresp", 32'(rsp_valid), 32'd0);
        applyStimulus(OP_ENC, 5, 0, 0, "nzero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
